usb_in_ep_ctrl: RTL and testbench



---
 rtl/usb_ep_pkg.sv | 24 ++
 rtl/ep_pkt_buf.sv | 28 ++
 rtl/usb_in_ep_ctrl.sv | 152 +++++++++++++++
 tb/tb_usb_in_ep_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// Package  : usb_ep_pkg
// Purpose  : shared state encodings, DATA PIDs and PID toggle helper
// Revision : 1.0 - initial release
//------------------------------------------------------------------
package usb_ep_pkg;

  typedef logic [1:0] ep_state_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] ZLP      = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  function automatic logic [3:0] pid_toggle(input logic [3:0] pid);
    return (pid == PID_DATA0) ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ep_pkt_buf.sv
`default_nettype none
//------------------------------------------------------------------
// Module   : ep_pkt_buf
// Purpose  : packet buffer, sync write / async read, single clock
// Revision : 1.0 - initial release
//------------------------------------------------------------------
module ep_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          r_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge r_clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/usb_in_ep_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// Module   : usb_in_ep_ctrl
// Purpose  : drains the byte queue into a packet buffer and answers IN tokens
// Revision : 1.0 - initial release
//------------------------------------------------------------------
module usb_in_ep_ctrl
  import usb_ep_pkg::*;
#(
  parameter int MAX_PKT = 64
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic [7:0] q_data,
  input  logic       q_empty,
  output logic       q_r_en,
  input  logic       in_token,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       tx_zlp,
  output logic       tx_nak,
  output logic [3:0] data_pid,
  input  logic       ack_rcvd,
  input  logic       ack_timeout,
  input  logic       toggle_clr,
  output logic       busy
);

  localparam int            CW    = $clog2(MAX_PKT + 1);
  localparam int            AW    = $clog2(MAX_PKT);
  localparam logic [CW-1:0] c_MAX = CW'(MAX_PKT);

  ep_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_idx;
  logic          r_locked;
  logic          r_zlp_pend;
  logic          r_tclr_pend;
  logic          r_nak;
  logic [3:0]    r_pid;

  logic          w_fill_en;
  logic          w_rd;
  logic [CW-1:0] w_cnt_next;
  logic          w_tclr;
  logic          w_zlp_pend;
  logic          w_last;
  logic          w_send;
  logic [7:0]    w_rdata;

  assign w_fill_en  = (r_state == IDLE) & ~r_locked & (r_cnt < c_MAX);
  // Gated by rst so the queue is never popped while reset is held.
  assign w_rd       = w_fill_en & ~q_empty & rst;
  assign w_cnt_next = r_cnt + CW'(w_rd);
  assign w_tclr     = toggle_clr | r_tclr_pend;
  assign w_zlp_pend = r_zlp_pend & ~w_tclr;
  assign w_send     = (r_state == SEND);
  assign w_last     = (r_idx == r_len - CW'(1));

  ep_pkt_buf #(
    .DEPTH (MAX_PKT)
  ) u_buf (
    .r_clk (r_clk),
    .we    (w_rd),
    .waddr (r_cnt[AW-1:0]),
    .wdata (q_data),
    .raddr (r_idx[AW-1:0]),
    .rdata (w_rdata)
  );

  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_locked    <= 1'b0;
      r_zlp_pend  <= 1'b0;
      r_tclr_pend <= 1'b0;
      r_nak       <= 1'b0;
      r_pid       <= PID_DATA0;
    end else begin
      r_nak <= 1'b0;
      if (w_rd) r_cnt <= w_cnt_next;
      if (toggle_clr && (r_state != IDLE)) r_tclr_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_tclr) begin
            r_pid       <= PID_DATA0;
            r_zlp_pend  <= 1'b0;
            r_tclr_pend <= 1'b0;
          end
          if (in_token) begin
            // A locked buffer is a retry: cnt still equals len, len==0 means a ZLP retry.
            if (w_cnt_next != '0) begin
              r_state  <= SEND;
              r_locked <= 1'b1;
              r_len    <= w_cnt_next;
              r_idx    <= '0;
            end else if (r_locked || w_zlp_pend) begin
              r_state <= ZLP;
            end else begin
              r_nak <= 1'b1;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (w_last) begin
              r_state <= WAIT_ACK;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + CW'(1);
            end
          end
        end
        ZLP: begin
          r_len    <= '0;
          r_locked <= 1'b1;
          r_state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_rcvd) begin
            r_pid      <= pid_toggle(r_pid);
            r_zlp_pend <= (r_len == c_MAX);
            r_cnt      <= '0;
            r_locked   <= 1'b0;
            r_state    <= IDLE;
          end else if (ack_timeout) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q_r_en   = w_rd;
  assign tx_valid = w_send;
  assign tx_data  = w_send ? w_rdata : 8'h00;
  assign tx_last  = w_send & w_last;
  assign tx_zlp   = (r_state == ZLP);
  assign tx_nak   = r_nak;
  assign data_pid = r_pid;
  assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_in_ep_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// Module   : tb_usb_in_ep_ctrl
// Purpose  : vector table, directed sequences and random packet scoreboard
// Revision : 1.0 - initial release
//------------------------------------------------------------------
module tb_usb_in_ep_ctrl;
  import usb_ep_pkg::*;

  logic       r_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] q_data;
  logic       q_empty;
  logic       q_r_en;
  logic       in_token = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_zlp, tx_nak, busy;
  logic       tx_ready = 1'b0;
  logic [3:0] data_pid;
  logic       ack_rcvd = 1'b0, ack_timeout = 1'b0, toggle_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  usb_in_ep_ctrl #(.MAX_PKT(64)) dut (
    .r_clk(r_clk), .rst(rst), .q_data(q_data), .q_empty(q_empty), .q_r_en(q_r_en),
    .in_token(in_token), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_zlp(tx_zlp), .tx_nak(tx_nak), .data_pid(data_pid),
    .ack_rcvd(ack_rcvd), .ack_timeout(ack_timeout), .toggle_clr(toggle_clr), .busy(busy)
  );

  always #5 r_clk = ~r_clk;

  // Byte queue model: flat array with read/write counters.
  logic [7:0] qmem [4096];
  int qwr = 0;
  int qrd = 0;
  int pops = 0;
  assign q_empty = (qwr == qrd);
  assign q_data  = qmem[qrd[11:0]];
  always @(posedge r_clk) begin
    if (q_r_en && !q_empty) begin
      qrd  <= qrd + 1;
      pops <= pops + 1;
    end
  end

  typedef struct packed {
    logic       tok, rdy, ack;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last, e_nak, e_busy;
    logic [3:0] e_pid;
  } vec_t;

  function automatic vec_t mk(input logic tok, input logic rdy, input logic ack, input logic v,
                              input logic [7:0] d, input logic l, input logic n, input logic b,
                              input logic [3:0] pid);
    vec_t x;
    x = '{tok, rdy, ack, v, d, l, n, b, pid};
    return x;
  endfunction

  vec_t vecs [9];

  logic [7:0] rx_q [$];
  logic [7:0] stream_m [$];
  bit   got_nak, got_zlp;
  int   last_pos;
  logic [3:0] pid_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    qmem[qwr[11:0]] = v;
    qwr = qwr + 1;
    stream_m.push_back(v);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    in_token = 0; tx_ready = 0; ack_rcvd = 0; ack_timeout = 0; toggle_clr = 0;
    repeat (3) step();
    rst = 1'b1;
    stream_m.delete();
  endtask

  task automatic finish_pkt(input logic ack, input logic tmo);
    step();
    in_token = 0; tx_ready = 0; ack_rcvd = ack; ack_timeout = tmo;
    step();
    ack_rcvd = 0; ack_timeout = 0;
    #1;
  endtask

  // mode 0: always ready, 1: fixed ready pattern, 2: random ready + spurious tokens
  task automatic collect(input int mode);
    bit [5:0] pat = 6'b101001;
    bit started = 0;
    bit done = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [7:0] pd = 8'h00;
    rx_q.delete();
    got_nak = 0; got_zlp = 0; last_pos = -1; pid_seen = 4'h0;
    step();
    in_token = 1; tx_ready = 1;
    for (int k = 0; k < 400; k++) begin
      step();
      in_token = (mode == 2) && started && ($urandom_range(0, 7) == 0);
      case (mode)
        0: tx_ready = 1;
        1: tx_ready = (k < 6) ? pat[k] : 1'b1;
        default: tx_ready = $urandom_range(0, 1) != 0;
      endcase
      #1;
      if (pv && !pr)
        check("hold_stable", {tx_valid, tx_data, tx_last}, {1'b1, pd, pl});
      if (tx_nak) begin
        if (started) check("nak_in_send", 1, 0);
        got_nak = 1; done = 1; break;
      end
      if (tx_zlp) begin
        got_zlp = 1; pid_seen = data_pid; done = 1; break;
      end
      if (tx_valid) begin
        started = 1;
        pid_seen = data_pid;
        if (tx_ready) begin
          rx_q.push_back(tx_data);
          if (tx_last) begin
            last_pos = rx_q.size() - 1; done = 1; break;
          end
        end
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
    end
    in_token = 0;
    check("collect_done", done, 1);
  endtask

  function automatic bit payload_bad(input int len);
    bit bad = (rx_q.size() != len);
    for (int i = 0; i < rx_q.size(); i++)
      if (i >= stream_m.size() || rx_q[i] !== stream_m[i]) bad = 1;
    return bad;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [3:0] pid_m;
    bit zlp_pend_m, retry_valid;
    int retry_len;

    // ---------------- reset state ----------------
    step();
    #1;
    check("reset_state", {tx_valid, tx_last, tx_zlp, tx_nak, busy, q_r_en, data_pid},
          {6'b000000, PID_DATA0});
    do_reset();

    // ---------------- vector table: 3-byte packet, ACK, then NAK ----------------
    vecs[0] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0, PID_DATA0);
    vecs[1] = mk(0, 1, 0, 1, 8'hA1, 0, 0, 1, PID_DATA0);
    vecs[2] = mk(0, 1, 0, 1, 8'hA2, 0, 0, 1, PID_DATA0);
    vecs[3] = mk(0, 1, 0, 1, 8'hA3, 1, 0, 1, PID_DATA0);
    vecs[4] = mk(0, 0, 1, 0, 8'h00, 0, 0, 1, PID_DATA0);
    vecs[5] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, PID_DATA1);
    vecs[6] = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, PID_DATA1);
    vecs[7] = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, PID_DATA1);
    vecs[8] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, PID_DATA1);
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (5) step();
    for (int i = 0; i < 9; i++) begin
      step();
      in_token = vecs[i].tok; tx_ready = vecs[i].rdy; ack_rcvd = vecs[i].ack;
      #1;
      check($sformatf("vec%0d", i),
            {tx_valid, (vecs[i].e_valid ? tx_data : 8'h00), tx_last, tx_nak, tx_zlp, busy, q_r_en, data_pid},
            {vecs[i].e_valid, vecs[i].e_data, vecs[i].e_last, vecs[i].e_nak, 1'b0, vecs[i].e_busy, 1'b0, vecs[i].e_pid});
    end
    in_token = 0; tx_ready = 0; ack_rcvd = 0;

    // ---------------- 64-byte packet, ZLP, NAK ----------------
    do_reset();
    for (int i = 0; i < 64; i++) push(8'(i));
    repeat (70) step();
    collect(0);
    check("t3_payload", payload_bad(64), 0);
    check("t3_last", last_pos, 63);
    check("t3_pid", pid_seen, PID_DATA0);
    finish_pkt(1, 0);
    check("t3_pid_after_ack", {busy, data_pid}, {1'b0, PID_DATA1});
    stream_m.delete();
    collect(0);
    check("t3_zlp", {got_zlp, pid_seen}, {1'b1, PID_DATA1});
    finish_pkt(1, 0);
    check("t3_pid_after_zlp", data_pid, PID_DATA0);
    collect(0);
    check("t3_nak", {got_nak, got_zlp}, 2'b10);

    // ---------------- timeout retry ----------------
    do_reset();
    push(8'h55); push(8'h66);
    repeat (5) step();
    collect(0);
    check("t4_first", payload_bad(2), 0);
    finish_pkt(0, 1);
    push(8'h77);
    p0 = pops;
    repeat (3) step();
    collect(0);
    check("t4_retry_payload", payload_bad(2), 0);
    check("t4_retry_pid", pid_seen, PID_DATA0);
    check("t4_no_read", pops, p0);
    finish_pkt(1, 0);
    void'(stream_m.pop_front()); void'(stream_m.pop_front());
    repeat (3) step();
    check("t4_read_after_ack", pops, p0 + 1);
    collect(0);
    check("t4_next", {payload_bad(1), pid_seen}, {1'b0, PID_DATA1});
    finish_pkt(1, 0);

    // ---------------- ready throttling, pending toggle_clr ----------------
    do_reset();
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (6) step();
    collect(1);
    check("t5_payload", payload_bad(4), 0);
    check("t5_last", last_pos, 3);
    step(); tx_ready = 0; toggle_clr = 1;
    step(); toggle_clr = 0; ack_rcvd = 1;
    step(); ack_rcvd = 0;
    step(); #1;
    check("t5_tclr_pending", data_pid, PID_DATA0);

    // ---------------- reset during SEND ----------------
    do_reset();
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (6) step();
    in_token = 1; tx_ready = 1;
    step(); in_token = 0;
    step(); #1;
    check("t6_second_byte", {tx_valid, tx_data}, {1'b1, 8'hD1});
    rst = 0;
    #1;
    check("t6_reset_outputs", {tx_valid, tx_data, tx_last, tx_zlp, tx_nak, busy, q_r_en, data_pid},
          {14'h0, PID_DATA0});
    repeat (2) step();
    rst = 1; tx_ready = 0;
    stream_m.delete();
    repeat (2) step();
    collect(0);
    check("t6_nak", got_nak, 1);

    // ---------------- random traffic vs packet-level scoreboard ----------------
    do_reset();
    pid_m = PID_DATA0; zlp_pend_m = 0; retry_valid = 0; retry_len = 0;
    for (int it = 0; it < 40; it++) begin
      int n, avail_cap, len, r, mode;
      bit long_wait, exact;
      n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 70);
      if (it % 9 == 4) n = 64 - (stream_m.size() % 64);
      for (int i = 0; i < n; i++) push(8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        step(); toggle_clr = 1;
        step(); toggle_clr = 0;
        pid_m = PID_DATA0; zlp_pend_m = 0;
      end
      long_wait = $urandom_range(0, 1) != 0;
      repeat (long_wait ? 70 : $urandom_range(0, 4)) step();
      mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      avail_cap = (stream_m.size() < 64) ? stream_m.size() : 64;
      collect(mode);
      len = rx_q.size();
      if (retry_valid) begin
        check("rnd_retry_kind", {got_zlp, last_pos >= 0}, (retry_len == 0) ? 2'b10 : 2'b01);
        check("rnd_retry_payload", payload_bad(retry_len), 0);
        check("rnd_retry_pid", pid_seen, pid_m);
      end else if (stream_m.size() == 0) begin
        check("rnd_empty_kind", {got_nak, got_zlp}, zlp_pend_m ? 2'b01 : 2'b10);
        if (got_zlp) check("rnd_zlp_pid", pid_seen, pid_m);
      end else begin
        exact = long_wait;
        check("rnd_pkt_kind", {got_nak, got_zlp, last_pos >= 0}, 3'b001);
        if (exact) check("rnd_len", len, avail_cap);
        else       check("rnd_len_range", (len >= 1) && (len <= avail_cap), 1);
        check("rnd_payload", payload_bad(len), 0);
        check("rnd_pid", pid_seen, pid_m);
      end
      if (!got_nak) begin
        r = $urandom_range(0, 99);
        if (r < 25) begin
          finish_pkt(0, 1);
          retry_valid = 1; retry_len = len;
        end else begin
          finish_pkt(1, r >= 85);
          for (int i = 0; i < len; i++) void'(stream_m.pop_front());
          zlp_pend_m = (len == 64);
          pid_m = pid_toggle(pid_m);
          retry_valid = 0;
        end
        check("rnd_after_handshake", {busy, data_pid}, {1'b0, pid_m});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
